coin_accum_ctrl: RTL and testbench

Controller that sits downstream of the per-button debounced pulse generators in the coin counter. It captures single-cycle coin pulses from four denomination buttons plus a clear button and arbitrates between them round-robin. It applies one event at a time to a saturating binary running total, then sequences an iterative binary-to-BCD conversion that feeds the 4-digit display driver.

---
 rtl/coin_accum_ctrl.sv | 175 +++++++++++++++++
 tb/tb_coin_accum_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_accum_ctrl.sv
// Coin accumulator: captures debounced coin/clear pulses, arbitrates round-robin,
// keeps a saturating binary total and converts it to 4-digit BCD by double dabble.
module coin_accum_ctrl #(
   parameter int unsigned VAL0      = 1,
   parameter int unsigned VAL1      = 5,
   parameter int unsigned VAL2      = 10,
   parameter int unsigned VAL3      = 25,
   parameter int unsigned MAX_TOTAL = 9999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  coin_pulse,
   input  logic        clr_pulse,
   output logic [13:0] total,
   output logic [15:0] bcd,
   output logic        bcd_valid,
   output logic        busy,
   output logic        overflow,
   output logic        lost
);

   localparam int unsigned NREQ      = 4;
   localparam int unsigned TW        = 14;
   localparam int unsigned SW        = 15;
   localparam int unsigned BW        = 16;
   localparam int unsigned DW        = TW + BW;
   localparam int unsigned CW        = 4;
   localparam int unsigned LAST_ITER = TW - 1;

   typedef enum logic {IDLE, CONV} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] pend_q, pend_d;
   logic            clr_pend_q, clr_pend_d;
   logic [1:0]      rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]   total_q, total_d;
   logic            overflow_q, overflow_d;
   logic            lost_q, lost_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            bcd_valid_q, bcd_valid_d;
   logic            busy_q, busy_d;
   logic [DW-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [1:0]      grant;
   logic [NREQ-1:0] svc;
   logic            clr_svc;
   logic [SW-1:0]   sum;

   function automatic logic [SW-1:0] req_val(input logic [1:0] idx);
      logic [SW-1:0] v;
      case (idx)
         2'd0:    v = SW'(VAL0);
         2'd1:    v = SW'(VAL1);
         2'd2:    v = SW'(VAL2);
         default: v = SW'(VAL3);
      endcase
      return v;
   endfunction

   // One double-dabble iteration: add 3 to each BCD digit >= 5, then shift left.
   function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] s);
      logic [DW-1:0] t;
      t = s;
      for (int d = 0; d < 4; d++) begin
         if (t[TW+4*d +: 4] >= 4'd5) begin
            t[TW+4*d +: 4] = t[TW+4*d +: 4] + 4'd3;
         end
      end
      return {t[DW-2:0], 1'b0};
   endfunction

   // First pending requester at or after rr_ptr, wrapping 3 -> 0.
   always_comb begin
      grant = rr_ptr_q;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (pend_q[rr_ptr_q + 2'(i)]) begin
            grant = rr_ptr_q + 2'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      total_d     = total_q;
      overflow_d  = overflow_q;
      bcd_d       = bcd_q;
      bcd_valid_d = 1'b0;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      svc         = '0;
      clr_svc     = 1'b0;
      sum         = '0;

      case (state_q)
         IDLE: begin
            if (clr_pend_q) begin
               total_d    = '0;
               overflow_d = 1'b0;
               clr_svc    = 1'b1;
               shreg_d    = '0;
               cnt_d      = '0;
               state_d    = CONV;
            end else if (|pend_q) begin
               sum = SW'(total_q) + req_val(grant);
               if (sum > SW'(MAX_TOTAL)) begin
                  total_d    = TW'(MAX_TOTAL);
                  overflow_d = 1'b1;
               end else begin
                  total_d = sum[TW-1:0];
               end
               svc[grant] = 1'b1;
               rr_ptr_d   = grant + 2'd1;
               shreg_d    = DW'(total_d);
               cnt_d      = '0;
               state_d    = CONV;
            end
         end
         CONV: begin
            shreg_d = dd_step(shreg_q);
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == CW'(LAST_ITER)) begin
               bcd_d       = shreg_d[DW-1:TW];
               bcd_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
      endcase

      // A new pulse on the servicing edge wins over the service clear.
      pend_d     = (pend_q & ~svc) | coin_pulse;
      clr_pend_d = (clr_pend_q & ~clr_svc) | clr_pulse;
      lost_d     = lost_q | (|(coin_pulse & pend_q & ~svc));
      busy_d     = (state_d == CONV);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         clr_pend_q  <= 1'b0;
         rr_ptr_q    <= '0;
         total_q     <= '0;
         overflow_q  <= 1'b0;
         lost_q      <= 1'b0;
         bcd_q       <= '0;
         bcd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         shreg_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         clr_pend_q  <= clr_pend_d;
         rr_ptr_q    <= rr_ptr_d;
         total_q     <= total_d;
         overflow_q  <= overflow_d;
         lost_q      <= lost_d;
         bcd_q       <= bcd_d;
         bcd_valid_q <= bcd_valid_d;
         busy_q      <= busy_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
      end
   end

   assign total     = total_q;
   assign bcd       = bcd_q;
   assign bcd_valid = bcd_valid_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;
   assign lost      = lost_q;

endmodule

// File: tb/tb_coin_accum_ctrl.sv
// Bench for coin_accum_ctrl: directed scenarios plus randomized pulses against an
// event-level reference model (decimal digits computed by division).
module tb_coin_accum_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  coin_pulse;
   logic        clr_pulse;
   logic [13:0] total;
   logic [15:0] bcd;
   logic        bcd_valid;
   logic        busy;
   logic        overflow;
   logic        lost;

   int checks;
   int failures;

   coin_accum_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .coin_pulse (coin_pulse),
      .clr_pulse  (clr_pulse),
      .total      (total),
      .bcd        (bcd),
      .bcd_valid  (bcd_valid),
      .busy       (busy),
      .overflow   (overflow),
      .lost       (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each grant starts a 14-cycle conversion, after which the
   // decimal value of the granted total is published for one cycle.
   int       vals [4] = '{1, 5, 10, 25};
   int       m_total, m_rr, m_left, m_conv, m_g;
   bit       m_ovf, m_lost, m_clrp, m_valid, m_csvc;
   bit [3:0] m_pend, m_svc;
   logic [15:0] m_bcd;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_total = 0; m_rr = 0; m_left = 0; m_conv = 0;
         m_ovf = 0; m_lost = 0; m_clrp = 0; m_valid = 0;
         m_pend = '0; m_bcd = '0;
      end else begin
         m_svc = '0; m_csvc = 0; m_valid = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_bcd = to_bcd(m_conv);
               m_valid = 1;
            end
         end else if (m_clrp) begin
            m_total = 0; m_ovf = 0; m_csvc = 1; m_conv = 0; m_left = 14;
         end else if (m_pend != 0) begin
            m_g = -1;
            for (int i = 0; i < 4; i++)
               if (m_g < 0 && m_pend[(m_rr + i) % 4]) m_g = (m_rr + i) % 4;
            if (m_total + vals[m_g] > 9999) begin
               m_total = 9999; m_ovf = 1;
            end else begin
               m_total = m_total + vals[m_g];
            end
            m_svc[m_g] = 1; m_rr = (m_g + 1) % 4; m_conv = m_total; m_left = 14;
         end
         m_lost = m_lost | (|(coin_pulse & m_pend & ~m_svc));
         m_pend = (m_pend & ~m_svc) | coin_pulse;
         m_clrp = (m_clrp & ~m_csvc) | clr_pulse;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; coin_pulse = '0; clr_pulse = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One-cycle pulse; returns at the negedge of the cycle after the pulse.
   task automatic drive(input logic [3:0] c, input logic cl);
      @(negedge clk);
      coin_pulse = c; clr_pulse = cl;
      @(negedge clk);
      coin_pulse = '0; clr_pulse = 1'b0;
   endtask

   // Edges until bcd_valid is seen (sampled 1 time unit after the edge); -1 on timeout.
   task automatic wait_valid(output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (bcd_valid) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0; coin_pulse = '0; clr_pulse = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({total, bcd, bcd_valid, busy, overflow, lost} !== 34'd0) begin
         failures++; $display("FAIL reset_init: outputs=%h expected 0", {total, bcd, bcd_valid, busy, overflow, lost});
      end
      rst_n = 1'b1;
      drive(4'b1101, 1'b0);
      repeat (3) wait_valid(n);
      drive(4'b0001, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (total !== 14'd37 || busy !== 1'b1) begin
         failures++; $display("FAIL reset_pre: total=%0d busy=%b expected 37 1", total, busy);
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({total, bcd, bcd_valid, busy, overflow, lost} !== 34'd0) begin
         failures++; $display("FAIL reset_midconv: outputs=%h expected 0", {total, bcd, bcd_valid, busy, overflow, lost});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         checks++;
         if (bcd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_after: bcd_valid=%b busy=%b expected 0 0", bcd_valid, busy);
         end
      end
   endtask

   task automatic test_single();
      int n;
      do_reset();
      drive(4'b1000, 1'b0);
      @(posedge clk); #1;
      checks++;
      if (total !== 14'd25 || busy !== 1'b1) begin
         failures++; $display("FAIL single_grant: total=%0d busy=%b expected 25 1", total, busy);
      end
      wait_valid(n);
      checks++;
      if (n !== 14 || bcd !== 16'h0025 || busy !== 1'b0) begin
         failures++; $display("FAIL single_bcd: n=%0d bcd=%h busy=%b expected 14 0025 0", n, bcd, busy);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      int exp_tot [4] = '{1, 6, 16, 41};
      logic [15:0] exp_bcd [4] = '{16'h0001, 16'h0006, 16'h0016, 16'h0041};
      do_reset();
      drive(4'b1111, 1'b0);
      for (int e = 0; e < 4; e++) begin
         wait_valid(n);
         checks++;
         if (n !== 15 || total !== 14'(exp_tot[e]) || bcd !== exp_bcd[e]) begin
            failures++;
            $display("FAIL simul_%0d: n=%0d total=%0d bcd=%h expected 15 %0d %h", e, n, total, bcd, exp_tot[e], exp_bcd[e]);
         end
      end
      checks++;
      if (lost !== 1'b0) begin
         failures++; $display("FAIL simul_lost: lost=%b expected 0", lost);
      end
   endtask

   task automatic test_round_robin();
      int n;
      do_reset();
      drive(4'b0010, 1'b0);
      drive(4'b1001, 1'b0);
      wait_valid(n);
      wait_valid(n);
      checks++;
      if (total !== 14'd30 || bcd !== 16'h0030) begin
         failures++; $display("FAIL rr_first: total=%0d bcd=%h expected 30 0030", total, bcd);
      end
      wait_valid(n);
      checks++;
      if (total !== 14'd31 || bcd !== 16'h0031) begin
         failures++; $display("FAIL rr_second: total=%0d bcd=%h expected 31 0031", total, bcd);
      end
   endtask

   task automatic test_saturation_clear();
      int n;
      int timeouts = 0;
      do_reset();
      for (int i = 0; i < 399; i++) begin
         drive(4'b1000, 1'b0);
         wait_valid(n);
         if (n < 0) timeouts++;
      end
      drive(4'b0110, 1'b0);
      wait_valid(n);
      wait_valid(n);
      checks++;
      if (timeouts != 0 || total !== 14'd9990 || bcd !== 16'h9990 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL sat_pre: timeouts=%0d total=%0d bcd=%h ovf=%b expected 0 9990 9990 0", timeouts, total, bcd, overflow);
      end
      drive(4'b1000, 1'b0);
      wait_valid(n);
      checks++;
      if (total !== 14'd9999 || bcd !== 16'h9999 || overflow !== 1'b1) begin
         failures++; $display("FAIL sat_hit: total=%0d bcd=%h ovf=%b expected 9999 9999 1", total, bcd, overflow);
      end
      drive(4'b0000, 1'b1);
      wait_valid(n);
      checks++;
      if (total !== 14'd0 || bcd !== 16'h0000 || overflow !== 1'b0) begin
         failures++; $display("FAIL clear: total=%0d bcd=%h ovf=%b expected 0 0000 0", total, bcd, overflow);
      end
   endtask

   task automatic test_lost_set_wins();
      int n;
      do_reset();
      drive(4'b0010, 1'b0);
      drive(4'b0010, 1'b0);
      drive(4'b0010, 1'b0);
      checks++;
      if (lost !== 1'b1) begin
         failures++; $display("FAIL lost_set: lost=%b expected 1", lost);
      end
      wait_valid(n);
      wait_valid(n);
      checks++;
      if (total !== 14'd10 || bcd !== 16'h0010) begin
         failures++; $display("FAIL lost_total: total=%0d bcd=%h expected 10 0010", total, bcd);
      end
      wait_valid(n);
      checks++;
      if (n !== -1 || total !== 14'd10) begin
         failures++; $display("FAIL lost_extra: n=%0d total=%0d expected -1 10", n, total);
      end
      do_reset();
      @(negedge clk); coin_pulse = 4'b0100;
      @(negedge clk); coin_pulse = 4'b0100;
      @(negedge clk); coin_pulse = 4'b0000;
      wait_valid(n);
      checks++;
      if (total !== 14'd10 || bcd !== 16'h0010) begin
         failures++; $display("FAIL setwins_first: total=%0d bcd=%h expected 10 0010", total, bcd);
      end
      wait_valid(n);
      checks++;
      if (n !== 15 || total !== 14'd20 || bcd !== 16'h0020 || lost !== 1'b0) begin
         failures++; $display("FAIL setwins_second: n=%0d total=%0d bcd=%h lost=%b expected 15 20 0020 0", n, total, bcd, lost);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         coin_pulse = '0;
         for (int b = 0; b < 4; b++) coin_pulse[b] = ($urandom_range(0, 15) == 0);
         clr_pulse = ($urandom_range(0, 63) == 0);
         @(posedge clk); #1;
         checks++;
         if (total !== 14'(m_total) || bcd !== m_bcd || bcd_valid !== m_valid ||
             busy !== (m_left > 0) || overflow !== m_ovf || lost !== m_lost) begin
            failures++;
            if (errs < 10)
               $display("FAIL random_cyc%0d: total=%0d bcd=%h v=%b busy=%b ovf=%b lost=%b expected %0d %h %b %b %b %b",
                        c, total, bcd, bcd_valid, busy, overflow, lost, m_total, m_bcd, m_valid, m_left > 0, m_ovf, m_lost);
            errs++;
         end
      end
      @(negedge clk);
      coin_pulse = '0; clr_pulse = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      coin_pulse = '0;
      clr_pulse = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_round_robin();
      test_saturation_clear();
      test_lost_set_wins();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
